// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART frame receiver.
// Holds the receiver state encoding, legal prescale ratios and mid-bit sample offsets.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Samples sit at P/2 - SAMPLE_PRE_OFS, P/2 and P/2 + SAMPLE_POST_OFS.
    localparam int SAMPLE_PRE_OFS  = 1;
    localparam int SAMPLE_POST_OFS = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame_receiver_if.sv
// Serial line, frame configuration and received-word signals of the UART receiver.
// master drives the line and configuration; slave is the receiver itself.
interface uart_rx_frame_receiver_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) ();

    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    rx_state_e             state_dbg;

    // data_valid, par_err and stp_err are single-cycle pulses with no back-pressure;
    // P_DATA is stable between pulses and only changes together with data_valid.
    modport master (
        output RX_IN, prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err, state_dbg
    );

    modport slave (
        input  RX_IN, prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err, state_dbg
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Mid-bit three-sample capture with majority vote; sample_done pulses the cycle
// after the vote is registered (edge P/2+2).
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] P,
    output logic                  sampled_bit,
    output logic                  sample_done
);

    localparam logic [PRESCALE_W-1:0] PRE_OFS  = PRESCALE_W'(SAMPLE_PRE_OFS);
    localparam logic [PRESCALE_W-1:0] POST_OFS = PRESCALE_W'(SAMPLE_POST_OFS);

    logic [PRESCALE_W-1:0] half;
    logic                  s0;
    logic                  s1;

    assign half = P >> 1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s0          <= 1'b1;
            s1          <= 1'b1;
            sampled_bit <= 1'b1;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (en) begin
                if (edge_cnt == half - PRE_OFS) s0 <= RX_IN;
                if (edge_cnt == half)           s1 <= RX_IN;
                // Third sample is taken straight off the line and voted in the same edge.
                if (edge_cnt == half + POST_OFS) begin
                    sampled_bit <= maj3(s0, s1, RX_IN);
                    sample_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_receiver.sv
// UART frame receiver: start-bit detection with glitch rejection, LSB-first
// deserialization, optional parity and stop checks, one-cycle result pulses.
module uart_rx_frame_receiver
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    uart_rx_frame_receiver_if.slave  bus
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [PRESCALE_W-1:0] EDGE_ONE  = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_WIDTH);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] p_lat;
    logic [PRESCALE_W-1:0] p_sel;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  stp_bad;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  sampled_bit;
    logic                  sample_done;
    logic                  start_det;
    logic                  bit_end;
    logic                  glitch;
    logic                  frame_end;
    logic                  par_exp;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .en          (state_q != IDLE),
        .RX_IN       (bus.RX_IN),
        .edge_cnt    (edge_cnt),
        .P           (p_lat),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done)
    );

    // Anything other than the three supported ratios falls back to 8x.
    assign p_sel = (bus.prescale == PRESCALE_W'(PRESCALE_8)  ||
                    bus.prescale == PRESCALE_W'(PRESCALE_16) ||
                    bus.prescale == PRESCALE_W'(PRESCALE_32)) ? bus.prescale
                                                              : PRESCALE_W'(PRESCALE_8);

    assign start_det = (state_q == IDLE) && !bus.RX_IN;
    assign bit_end   = (edge_cnt == p_lat - EDGE_ONE);
    assign glitch    = (state_q == START) && sample_done && sampled_bit;
    assign frame_end = (state_q == STOP) && bit_end;
    assign par_exp   = par_typ_q ? ~^shreg : ^shreg;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.RX_IN) state_d = START;
            START: begin
                if (glitch)       state_d = IDLE;
                else if (bit_end) state_d = DATA;
            end
            DATA:    if (bit_end && bit_cnt == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            p_lat        <= PRESCALE_W'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad      <= 1'b0;
            stp_bad      <= 1'b0;
            shreg        <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            // The low sample seen in IDLE is edge 0, so the count resumes at 1.
            if (state_q == IDLE)      edge_cnt <= start_det ? EDGE_ONE : '0;
            else if (glitch || bit_end) edge_cnt <= '0;
            else                      edge_cnt <= edge_cnt + EDGE_ONE;

            if (start_det) begin
                p_lat     <= p_sel;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                par_bad   <= 1'b0;
                stp_bad   <= 1'b0;
                bit_cnt   <= '0;
            end

            if (sample_done) begin
                case (state_q)
                    DATA: begin
                        shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                    PARITY:  par_bad <= (sampled_bit != par_exp);
                    STOP:    stp_bad <= !sampled_bit;
                    default: ;
                endcase
            end

            if (frame_end) begin
                data_valid_q <= !(par_bad | stp_bad);
                par_err_q    <= par_bad;
                stp_err_q    <= stp_bad;
                if (!(par_bad | stp_bad)) p_data_q <= shreg;
            end
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Directed bench for the UART frame receiver: frames are driven bit by bit and
// the expected result word and completion cycle are queued for the monitor.
module tb_uart_rx_frame_receiver;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;
    localparam int EW = DW + 3;

    logic CLK;
    logic RST;
    int   cyc;
    int   n_checks;
    int   n_pass;

    // Expected word layout: {par_err, stp_err, data_valid, P_DATA}
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    uart_rx_frame_receiver_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

    uart_rx_frame_receiver #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    // Every driver step starts and ends on a falling edge.
    task automatic drive_bit(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [PW-1:0] cfg_p, input int p, input logic pe,
                              input logic pt, input logic [DW-1:0] d, input logic pbit,
                              input logic sbit, input logic [EW-1:0] exp_word);
        int nbits;
        nbits = pe ? DW + 3 : DW + 2;
        bus.prescale = cfg_p;
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        exp_q.push_back(exp_word);
        exp_cyc_q.push_back(cyc + p * nbits);
        drive_bit(1'b0, p);
        // Configuration must be ignored once the frame has started.
        bus.prescale = (cfg_p == PW'(16)) ? PW'(8) : PW'(16);
        bus.PAR_EN   = ~pe;
        bus.PAR_TYP  = ~pt;
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (!RST && (bus.data_valid || bus.par_err || bus.stp_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {21'd0, bus.par_err, bus.stp_err, bus.data_valid, bus.P_DATA}, 32'hFFFF_FFFF);
            end else begin
                check("frame_result", {21'd0, bus.par_err, bus.stp_err, bus.data_valid, bus.P_DATA},
                      {21'd0, exp_q.pop_front()});
                check("frame_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_pass       = 0;
        RST          = 1'b1;
        bus.RX_IN    = 1'b1;
        bus.prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        check("rst_state",      32'(bus.state_dbg), 32'(IDLE));
        check("rst_p_data",     32'(bus.P_DATA), 32'h0);
        check("rst_data_valid", 32'(bus.data_valid), 32'h0);
        check("rst_par_err",    32'(bus.par_err), 32'h0);
        check("rst_stp_err",    32'(bus.stp_err), 32'h0);
        idle(4);

        // 0xA5 even parity (4 ones -> parity 0), 88-cycle latency
        send_frame(PW'(8), 8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, {3'b001, 8'hA5});
        idle(6);

        // 2-cycle glitch must be rejected silently
        drive_bit(1'b0, 2);
        idle(12);
        check("glitch_state", 32'(bus.state_dbg), 32'(IDLE));
        send_frame(PW'(8), 8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, {3'b001, 8'h3C});
        idle(5);

        // 0xA5 odd parity expects 1; sent 0 -> par_err, P_DATA keeps 0x3C
        send_frame(PW'(16), 16, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, {3'b100, 8'h3C});
        idle(5);

        // 0x81 with a bad stop bit, then 0x7E back-to-back
        send_frame(PW'(8), 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, {3'b010, 8'h3C});
        send_frame(PW'(8), 8, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, {3'b001, 8'h7E});
        idle(5);

        // P=32 back-to-back: completions 320 cycles apart
        send_frame(PW'(32), 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, {3'b001, 8'h00});
        send_frame(PW'(32), 32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, {3'b001, 8'hFF});
        idle(5);

        // Illegal prescale 12 runs at 8x; 0x96 odd parity (4 ones -> parity 1)
        send_frame(PW'(12), 8, 1'b1, 1'b1, 8'h96, 1'b1, 1'b1, {3'b001, 8'h96});
        idle(5);

        // Reset during data bit 4 aborts the frame without pulses
        bus.prescale = PW'(8);
        bus.PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
        drive_bit(1'b0, 3);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        idle(100);
        check("abort_state", 32'(bus.state_dbg), 32'(IDLE));
        send_frame(PW'(8), 8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, {3'b001, 8'h55});
        idle(5);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
